// File: rtl/link_pkg.sv
// link_pkg: shared types and default constants for the inter-board link receiver.
package link_pkg;

    // Receiver sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FLIGHT = 2'd2
    } link_rx_state_t;

    localparam int SYNC_STAGES_DEF    = 2;
    localparam int STABLE_CYCLES_DEF  = 16;
    localparam int TIMEOUT_CYCLES_DEF = 600_000_000;   // 10 s at 60 MHz
    localparam int POWER_W            = 4;

endpackage

// File: rtl/link_filter.sv
// link_filter: SYNC_STAGES-deep synchroniser followed by a stability filter.
// The output only takes a new value after STABLE_CYCLES consecutive equal
// synchronised samples; for a bus, any bit change restarts the whole count,
// so the bus updates atomically.
module link_filter #(
    parameter int WIDTH         = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    localparam int             CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_sync;
    logic [WIDTH-1:0]                  r_cand;
    logic [WIDTH-1:0]                  w_cand_nxt;
    logic [CW-1:0]                     r_cnt;
    logic [CW-1:0]                     w_cnt_nxt;
    logic [WIDTH-1:0]                  r_q;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign o_q    = r_q;

    // Synchroniser chain: element 0 samples the raw line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    // Next candidate / saturating stability count
    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (w_sync != r_cand) begin
            w_cand_nxt = w_sync;
            w_cnt_nxt  = '0;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Candidate, count and filtered output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand <= '0;
            r_cnt  <= '0;
            r_q    <= '0;
        end else begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_MAX) begin
                r_q <= w_cand_nxt;
            end else begin
                r_q <= r_q;
            end
        end
    end

endmodule

// File: rtl/link_rx.sv
// link_rx: receiver for the inter-board game link. Filters the peer lines,
// turns the throw flag into start/end pulses and latches the thrown power.
// Optional feature macro: LINK_RX_TIMEOUT_EN (flight timeout + sticky link_err).
module link_rx
    import link_pkg::*;
#(
    parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES  = STABLE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic               clk60MHz,
    input  logic               rst,
    input  logic               in_player1_ready,
    input  logic               in_player2_ready,
    input  logic [POWER_W-1:0] in_power,
    input  logic               in_throw_flag,
    output logic               rx_player1_ready,
    output logic               rx_player2_ready,
    output logic               rx_throw_flag,
    output logic [POWER_W-1:0] rx_power,
    output logic               throw_start,
    output logic               throw_end,
    output logic               link_err
);

    // Filtered values are not trustworthy until the synchroniser and filter
    // have seen real samples; IDLE waits out this window so a flag that is
    // already high at reset release cannot look like a fresh low level.
    localparam int             HOLD     = SYNC_STAGES + STABLE_CYCLES;
    localparam int             HW       = $clog2(HOLD + 1);
    localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD);

    link_rx_state_t     r_state;
    logic [POWER_W-1:0] w_power;
    logic [POWER_W-1:0] r_pow_d;
    logic [POWER_W-1:0] r_rx_power;
    logic               w_flag;
    logic               r_start;
    logic               r_end;
    logic [HW-1:0]      r_hold;
    logic               w_hold_done;
    logic               w_timeout;
    logic               w_enter_flight;

    link_filter #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_flt_p1 (
        .clk(clk60MHz), .rst(rst), .i_d(in_player1_ready), .o_q(rx_player1_ready)
    );

    link_filter #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_flt_p2 (
        .clk(clk60MHz), .rst(rst), .i_d(in_player2_ready), .o_q(rx_player2_ready)
    );

    link_filter #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_flt_flag (
        .clk(clk60MHz), .rst(rst), .i_d(in_throw_flag), .o_q(w_flag)
    );

    link_filter #(.WIDTH(POWER_W), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES)) u_flt_pow (
        .clk(clk60MHz), .rst(rst), .i_d(in_power), .o_q(w_power)
    );

    assign rx_throw_flag  = w_flag;
    assign rx_power       = r_rx_power;
    assign throw_start    = r_start;
    assign throw_end      = r_end;
    assign w_hold_done    = (r_hold == HOLD_MAX);
    assign w_enter_flight = (r_state == ARMED) && w_flag;

    // Post-reset settling window counter (saturates once done)
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            r_hold <= '0;
        end else if (r_hold != HOLD_MAX) begin
            r_hold <= r_hold + 1'b1;
        end else begin
            r_hold <= r_hold;
        end
    end

`ifdef LINK_RX_TIMEOUT_EN
    localparam logic [29:0] TO_LAST = 30'(TIMEOUT_CYCLES - 1);

    logic [29:0] r_flight_cnt;
    logic        r_link_err;

    assign w_timeout = (r_flight_cnt >= TO_LAST);
    assign link_err  = r_link_err;

    // Flight length counter and sticky timeout error
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            r_flight_cnt <= 30'd0;
            r_link_err   <= 1'b0;
        end else begin
            if (w_enter_flight) begin
                r_flight_cnt <= 30'd0;
            end else if ((r_state == FLIGHT) && (r_flight_cnt != 30'h3FFF_FFFF)) begin
                r_flight_cnt <= r_flight_cnt + 30'd1;
            end else begin
                r_flight_cnt <= r_flight_cnt;
            end
            if ((r_state == FLIGHT) && w_flag && w_timeout) begin
                r_link_err <= 1'b1;
            end else begin
                r_link_err <= r_link_err;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign link_err  = 1'b0;
`endif

    // Throw sequencer with registered pulses and power latch. The latch uses
    // the power value held one cycle earlier, so a power update landing on
    // the same edge as the flag rise is not picked up.
    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pow_d    <= '0;
            r_rx_power <= '0;
            r_start    <= 1'b0;
            r_end      <= 1'b0;
        end else begin
            r_pow_d <= w_power;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hold_done && !w_flag) begin
                        r_state <= ARMED;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ARMED: begin
                    if (w_flag) begin
                        r_rx_power <= r_pow_d;
                        r_start    <= 1'b1;
                        r_state    <= FLIGHT;
                    end else begin
                        r_state <= ARMED;
                    end
                end
                FLIGHT: begin
                    if (!w_flag) begin
                        r_end   <= 1'b1;
                        r_state <= ARMED;
                    end else if (w_timeout) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= FLIGHT;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: directed self-checking bench for link_rx
// (SYNC_STAGES=2, STABLE_CYCLES=4, TIMEOUT_CYCLES=100).
// Timeout expectations follow LINK_RX_TIMEOUT_EN as seen by this file.
module tb_link_rx;

    logic       clk60MHz = 1'b0;
    logic       rst = 1'b1;
    logic       in_player1_ready = 1'b0;
    logic       in_player2_ready = 1'b0;
    logic [3:0] in_power = 4'h0;
    logic       in_throw_flag = 1'b0;
    logic       rx_player1_ready;
    logic       rx_player2_ready;
    logic       rx_throw_flag;
    logic [3:0] rx_power;
    logic       throw_start;
    logic       throw_end;
    logic       link_err;

    int n_vec = 0;
    int n_bad = 0;
    int n_start = 0;
    int n_end = 0;

    link_rx #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .clk60MHz(clk60MHz), .rst(rst),
        .in_player1_ready(in_player1_ready), .in_player2_ready(in_player2_ready),
        .in_power(in_power), .in_throw_flag(in_throw_flag),
        .rx_player1_ready(rx_player1_ready), .rx_player2_ready(rx_player2_ready),
        .rx_throw_flag(rx_throw_flag), .rx_power(rx_power),
        .throw_start(throw_start), .throw_end(throw_end), .link_err(link_err)
    );

    always #5 clk60MHz = ~clk60MHz;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk60MHz) begin
        if (throw_start) n_start <= n_start + 1;
        if (throw_end)   n_end   <= n_end + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk60MHz);
        #1;
    endtask

    // Wait (bounded) for a throw_start (sel=0) or throw_end (sel=1) pulse
    task automatic wait_pulse(input string tag, input bit sel, input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk60MHz);
            if (sel ? throw_end : throw_start) begin
                lat = i;
                break;
            end
        end
        chk(tag, 32'(lat > 0), 32'd1);
    endtask

    initial begin
        int lat;
        int lat2;
        int s0;
        int e0;
        bit seen;

        // Reset state
        tick(3);
        @(negedge clk60MHz);
        chk("rst_ready", {30'd0, rx_player1_ready, rx_player2_ready}, 32'd0);
        chk("rst_flag", rx_throw_flag, 1'b0);
        chk("rst_power", rx_power, 4'h0);
        chk("rst_pulses", {throw_start, throw_end, link_err}, 3'b000);
        @(posedge clk60MHz); #1;
        rst = 1'b0;
        tick(30);

        // Glitch rejection: 3-cycle pulse must not pass
        in_player1_ready = 1'b1;
        tick(3);
        in_player1_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk60MHz);
            if (rx_player1_ready) seen = 1'b1;
        end
        chk("glitch3_p1", seen, 1'b0);

        // 10-cycle pulse: appears about 6 clocks after the raw edge
        @(posedge clk60MHz); #1;
        in_player1_ready = 1'b1;
        in_player2_ready = 1'b1;
        lat = 0;
        lat2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk60MHz);
            if (rx_player1_ready && lat == 0)  lat = i;
            if (rx_player2_ready && lat2 == 0) lat2 = i;
            if (i == 10) begin
                in_player1_ready = 1'b0;
                in_player2_ready = 1'b0;
            end
        end
        chk("p1_latency_6pm1", 32'(lat >= 5 && lat <= 7), 32'd1);
        chk("p2_latency_6pm1", 32'(lat2 >= 5 && lat2 <= 7), 32'd1);
        chk("p1_back_low", rx_player1_ready, 1'b0);

        // Normal throw with power A
        tick(1);
        in_power = 4'hA;
        tick(20);
        chk("power_unlatched", rx_power, 4'h0);
        s0 = n_start;
        e0 = n_end;
        in_throw_flag = 1'b1;
        wait_pulse("start1_seen", 1'b0, 20, lat);
        chk("start1_power", rx_power, 4'hA);
        chk("start1_flag", rx_throw_flag, 1'b1);
        in_power = 4'h3;                       // change during flight
        repeat (44) @(negedge clk60MHz);
        chk("flight_power_hold", rx_power, 4'hA);
        in_throw_flag = 1'b0;
        wait_pulse("end1_seen", 1'b1, 20, lat);
        tick(2);
        chk("throw1_starts", n_start - s0, 32'd1);
        chk("throw1_ends", n_end - e0, 32'd1);
        chk("end1_power_hold", rx_power, 4'hA);

        // Second throw latches the new power
        tick(20);
        in_throw_flag = 1'b1;
        wait_pulse("start2_seen", 1'b0, 20, lat);
        chk("start2_power", rx_power, 4'h3);
        tick(20);
        in_throw_flag = 1'b0;
        wait_pulse("end2_seen", 1'b1, 20, lat);

        // Timeout: flag held high for 200 cycles
        tick(20);
        e0 = n_end;
        in_throw_flag = 1'b1;
        wait_pulse("start3_seen", 1'b0, 20, lat);
`ifdef LINK_RX_TIMEOUT_EN
        lat = 0;
        for (int i = 1; i <= 150; i++) begin
            @(negedge clk60MHz);
            if (link_err && lat == 0) lat = i;
        end
        chk("timeout_latency", 32'(lat >= 98 && lat <= 102), 32'd1);
        repeat (44) @(negedge clk60MHz);
        in_throw_flag = 1'b0;
        repeat (30) @(negedge clk60MHz);
        chk("timeout_no_end", n_end - e0, 32'd0);
        chk("timeout_err_sticky", link_err, 1'b1);
`else
        repeat (150) @(negedge clk60MHz);
        chk("no_timeout_err", link_err, 1'b0);
        repeat (44) @(negedge clk60MHz);
        in_throw_flag = 1'b0;
        wait_pulse("long_end_seen", 1'b1, 20, lat);
        chk("long_end_err", link_err, 1'b0);
`endif

        // Re-arm, then reset mid-flight with the flag still high
        tick(10);
        in_throw_flag = 1'b1;
        wait_pulse("start4_seen", 1'b0, 40, lat);
        tick(10);
        rst = 1'b1;
        @(negedge clk60MHz);
        chk("midrst_power", rx_power, 4'h0);
        chk("midrst_flag_err", {rx_throw_flag, link_err}, 2'b00);
        chk("midrst_pulses", {throw_start, throw_end}, 2'b00);
        tick(2);
        rst = 1'b0;
        s0 = n_start;
        e0 = n_end;
        tick(20);
        chk("flag_at_release_nostart", n_start - s0, 32'd0);
        chk("flag_at_release_level", rx_throw_flag, 1'b1);
        in_throw_flag = 1'b0;
        tick(8);
        chk("aborted_no_end", n_end - e0, 32'd0);
        in_throw_flag = 1'b1;
        wait_pulse("start5_seen", 1'b0, 20, lat);
        chk("start5_power", rx_power, 4'h3);
        tick(10);
        in_throw_flag = 1'b0;
        wait_pulse("end5_seen", 1'b1, 20, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/link_rx.md
# link_rx

Receiver for the inter-board game link driven by the peer FPGA: `in_player1_ready`, `in_player2_ready`, `in_power[3:0]` and `in_throw_flag`. It synchronises and glitch-filters each line. It turns the throw flag into start and end events and latches the thrown power. The filtered outputs feed `turn_manager`, `set_speed`, `set_ypos` and `simulate` in place of the raw pins.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages per input synchroniser; minimum 2.
- `STABLE_CYCLES`, 16: consecutive equal synchronised samples required before a filtered value changes; minimum 1.
- `TIMEOUT_CYCLES`, 600_000_000: maximum flight length in clocks (10 s at 60 MHz); used only with the timeout feature.

Ports:
- `clk60MHz`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `in_player1_ready`  in  1  raw peer line, asynchronous to `clk60MHz`.
- `in_player2_ready`  in  1  raw peer line, asynchronous.
- `in_power`  in  4  raw peer throw power, asynchronous.
- `in_throw_flag`  in  1  raw peer throw flag, asynchronous.
- `rx_player1_ready`  out  1  filtered level.
- `rx_player2_ready`  out  1  filtered level.
- `rx_throw_flag`  out  1  filtered flag level.
- `rx_power`  out  4  power latched at the last accepted throw start.
- `throw_start`  out  1  one-cycle pulse when a flight begins.
- `throw_end`  out  1  one-cycle pulse when a flight ends normally.
- `link_err`  out  1  sticky timeout flag.

## Operation
- **Synchroniser:** each raw line passes through `SYNC_STAGES` flip-flops, all reset to 0.
- **Filters:** there are four independent filters: ready1, ready2, flag, and power as a 4-bit bus.
  - Each filter holds `cand` and `cnt`. When the synchronised value differs from `cand`: `cand` takes the new value and `cnt` is set to 0.
  - Otherwise `cnt` increments, saturating. When `cnt` reaches `STABLE_CYCLES-1`, the filtered output takes `cand`.
  - A pulse shorter than `STABLE_CYCLES` clocks never reaches the filtered output.
  - For power, any bit change restarts the whole bus filter, so the bus updates atomically.
- **FSM states:** IDLE, ARMED, FLIGHT.
  - **IDLE:** entered at reset. Moves to ARMED once filtered flag = 0, so a flag already high at reset never produces a throw.
  - **ARMED:** on a filtered flag rising edge, `rx_power` takes the filtered power, `throw_start` = 1 for one cycle, and the FSM moves to FLIGHT.
  - **FLIGHT:** on a filtered flag falling edge, `throw_end` = 1 for one cycle and the FSM moves to ARMED.
  - **Power during FLIGHT:** changes are ignored; `rx_power` holds until the next `throw_start`.
- **Transmitter contract:** power is stable for at least `STABLE_CYCLES` clocks before the flag rises, and stays stable through the flight.
- **Simultaneous events:** if power and flag change filtered value on the same edge, `rx_power` takes the filtered power value held before that edge.
- **Reset mid-operation:** every register clears, the FSM goes to IDLE, and no `throw_end` is issued for the aborted flight.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Raw edge to filtered output: `SYNC_STAGES + STABLE_CYCLES` clocks, ±1 for sampling phase.
- `throw_start` is asserted in the cycle after `rx_throw_flag` first reads 1; `rx_power` is valid in that same cycle.
- `throw_end` is asserted in the cycle after `rx_throw_flag` first reads 0.
- The minimum accepted flight, and the minimum gap between flights, is `STABLE_CYCLES` clocks.

## Configuration
- Macro `LINK_RX_TIMEOUT_EN`.
- **Defined:**
  - A 30-bit flight counter clears on FLIGHT entry and increments each cycle in FLIGHT.
  - When it reaches `TIMEOUT_CYCLES`, `link_err` sets and the FSM moves to IDLE, with no `throw_end`. Re-arming needs filtered flag = 0.
  - `link_err` clears only on `rst`.
- **Undefined:** no counter exists, `link_err` is tied to 0, and FLIGHT waits indefinitely.

## Structure
- Package `link_pkg` holds:
  - the state enum `link_rx_state_t` (IDLE, ARMED, FLIGHT);
  - the default constants for `SYNC_STAGES`, `STABLE_CYCLES` and `TIMEOUT_CYCLES`;
  - `POWER_W` = 4.
- Sub-module `link_filter` (parameters `WIDTH`, `SYNC_STAGES`, `STABLE_CYCLES`) contains one synchroniser plus one stability filter. It is instantiated four times: three with `WIDTH` = 1 and one with `WIDTH` = `POWER_W`.
- FSM, power latch and timeout counter live in `link_rx`.

## Test plan
Bench parameters: `STABLE_CYCLES` = 4, `SYNC_STAGES` = 2, `TIMEOUT_CYCLES` = 100, macro defined unless noted.
- **Glitch rejection:** 3-cycle high pulse on `in_player1_ready` -> `rx_player1_ready` stays 0. A 10-cycle pulse -> it goes high 6±1 clocks after the raw edge.
- **Normal throw:** `in_power` = 4'hA settled, then flag high for 50 cycles -> one `throw_start` with `rx_power` = 4'hA, then one `throw_end`.
- **Power change in flight:** after `throw_start`, `in_power` = 4'h3 -> `rx_power` stays 4'hA. The next throw latches 4'h3.
- **Flag high at reset release:** no `throw_start` until the flag has gone low for at least 4 cycles and then risen again.
- **Timeout:** flag held high for 200 cycles -> `link_err` = 1 at about 100 cycles after `throw_start`, and no `throw_end`. With the macro undefined -> `link_err` = 0 and `throw_end` occurs on the flag fall.
- **Reset mid-flight:** `rst` pulse during FLIGHT -> all outputs 0, no `throw_end`, and `link_err` clears.
